idma_byte_lane_buffer: RTL and testbench

- Per-byte-lane dataflow buffer between the iDMA read backend and the OBI write backend.
- Each of StrbWidth byte lanes is an independent FIFO with its own valid/ready, so read-aligned and write-aligned bytes can enter and leave in different lane patterns.
- The output side drives the OBI write backend's buffer data, valid and ready inputs directly.
- Provides an all-empty status, used for idle and clean detection.

---
 rtl/idma_byte_lane_buffer_pkg.sv | 21 ++
 rtl/idma_byte_lane_buffer_checker.sv | 44 ++++
 rtl/idma_byte_lane_buffer_fifo.sv | 93 +++++++++
 rtl/idma_byte_lane_buffer.sv | 55 +++++
 tb/tb_idma_byte_lane_buffer.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/idma_byte_lane_buffer_pkg.sv
// Shared types and helpers for the iDMA per-byte-lane buffer between the
// read backend and the OBI write backend.
package idma_byte_lane_buffer_pkg;

  typedef logic [7:0] lane_byte_t;

  localparam int unsigned DefaultStrbWidth = 32'd16;
  localparam int unsigned DefaultDepth     = 32'd3;

  // Pointer increment modulo depth by explicit compare, so any depth works.
  function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned depth);
    int unsigned nxt;
    if (ptr >= (depth - 32'd1)) begin
      nxt = 32'd0;
    end else begin
      nxt = ptr + 32'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/idma_byte_lane_buffer_checker.sv
// Simulation assertions for the per-lane FIFO and for the lane buffer top.
// Kept apart from the datapath so the design files stay purely structural.
module idma_byte_lane_fifo_checker #(
  parameter int unsigned Depth    = 32'd3,
  parameter int unsigned PtrWidth = 32'd2,
  parameter int unsigned CntWidth = 32'd2
) (
  input logic                clk_i,
  input logic                rst_i,
  input logic                clear_i,
  input logic                valid_i,
  input logic                ready_o,
  input logic [PtrWidth-1:0] wr_ptr,
  input logic [CntWidth-1:0] count
);

  a_depth_legal : assert property (@(posedge clk_i) (Depth >= 32'd1));

  a_count_bound : assert property (@(posedge clk_i) disable iff (rst_i)
    (32'(count) <= Depth));

  // A request held against a full lane must not move the write pointer.
  a_no_push_when_full : assert property (@(posedge clk_i) disable iff (rst_i)
    (valid_i && !ready_o && !clear_i) |=> $stable(wr_ptr));

endmodule

module idma_byte_lane_buffer_checker #(
  parameter int unsigned StrbWidth = 32'd16,
  parameter int unsigned Depth     = 32'd3
) (
  input logic                 clk_i,
  input logic                 rst_i,
  input logic [StrbWidth-1:0] buffer_out_valid,
  input logic                 buffer_empty
);

  a_params_legal : assert property (@(posedge clk_i)
    (StrbWidth >= 32'd1) && (Depth >= 32'd1));

  a_empty_consistent : assert property (@(posedge clk_i) disable iff (rst_i)
    (buffer_empty == !(|buffer_out_valid)));

endmodule

// File: rtl/idma_byte_lane_buffer_fifo.sv
// Single byte-lane FIFO: no fall-through, no pop-through when full, and the
// head byte is forced to zero while the lane is empty.
module idma_byte_lane_fifo
  import idma_byte_lane_buffer_pkg::*;
#(
  parameter int unsigned Depth  = DefaultDepth,
  parameter type         byte_t = lane_byte_t
) (
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  clear_i,
  input  byte_t data_i,
  input  logic  valid_i,
  output logic  ready_o,
  output byte_t data_o,
  output logic  valid_o,
  input  logic  ready_i,
  output logic  empty_o
);

  localparam int unsigned PtrWidth = (Depth > 32'd1) ? $clog2(Depth) : 32'd1;
  localparam int unsigned CntWidth = $clog2(Depth + 32'd1);

  byte_t               mem_r [Depth];
  logic [PtrWidth-1:0] wr_ptr_r;
  logic [PtrWidth-1:0] rd_ptr_r;
  logic [CntWidth-1:0] count_r;
  logic                push_s;
  logic                pop_s;

  assign ready_o = (count_r < CntWidth'(Depth));
  assign valid_o = (count_r != CntWidth'(0));
  assign empty_o = (count_r == CntWidth'(0));
  assign push_s  = valid_i & ready_o;
  assign pop_s   = valid_o & ready_i;

  // Pointer and occupancy state; reset and clear drop any same-cycle handshake.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_r <= PtrWidth'(0);
      rd_ptr_r <= PtrWidth'(0);
      count_r  <= CntWidth'(0);
    end else if (clear_i) begin
      wr_ptr_r <= PtrWidth'(0);
      rd_ptr_r <= PtrWidth'(0);
      count_r  <= CntWidth'(0);
    end else begin
      if (push_s) begin
        wr_ptr_r <= PtrWidth'(wrap_inc(32'(wr_ptr_r), Depth));
      end
      if (pop_s) begin
        rd_ptr_r <= PtrWidth'(wrap_inc(32'(rd_ptr_r), Depth));
      end
      if (push_s && !pop_s) begin
        count_r <= count_r + CntWidth'(1);
      end else if (pop_s && !push_s) begin
        count_r <= count_r - CntWidth'(1);
      end
    end
  end

  // Storage write; contents are deliberately left out of reset.
  always_ff @(posedge clk_i) begin
    if (push_s && !rst_i && !clear_i) begin
      mem_r[wr_ptr_r] <= data_i;
    end
  end

  // Head byte, zeroed when empty so downstream masking sees a clean value.
  always_comb begin
    data_o = byte_t'(0);
    if (valid_o) begin
      data_o = mem_r[rd_ptr_r];
    end else begin
      data_o = byte_t'(0);
    end
  end

  idma_byte_lane_fifo_checker #(
    .Depth    (Depth),
    .PtrWidth (PtrWidth),
    .CntWidth (CntWidth)
  ) i_checker (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (clear_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .wr_ptr  (wr_ptr_r),
    .count   (count_r)
  );

endmodule

// File: rtl/idma_byte_lane_buffer.sv
// Per-byte-lane buffer: StrbWidth independent lane FIFOs feeding the OBI
// write backend, plus an all-lanes-empty flag for idle detection.
module idma_byte_lane_buffer
  import idma_byte_lane_buffer_pkg::*;
#(
  parameter int unsigned StrbWidth = DefaultStrbWidth,
  parameter int unsigned Depth     = DefaultDepth,
  parameter type         byte_t    = lane_byte_t,
  parameter type         strb_t    = logic [StrbWidth-1:0]
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  byte_t [StrbWidth-1:0] buffer_in_i,
  input  strb_t                 buffer_in_valid_i,
  output strb_t                 buffer_in_ready_o,
  output byte_t [StrbWidth-1:0] buffer_out_o,
  output strb_t                 buffer_out_valid_o,
  input  strb_t                 buffer_out_ready_i,
  output logic                  buffer_empty_o
);

  strb_t lane_empty_s;

  for (genvar i = 0; i < StrbWidth; i++) begin : g_lane
    idma_byte_lane_fifo #(
      .Depth  (Depth),
      .byte_t (byte_t)
    ) i_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clear_i (clear_i),
      .data_i  (buffer_in_i[i]),
      .valid_i (buffer_in_valid_i[i]),
      .ready_o (buffer_in_ready_o[i]),
      .data_o  (buffer_out_o[i]),
      .valid_o (buffer_out_valid_o[i]),
      .ready_i (buffer_out_ready_i[i]),
      .empty_o (lane_empty_s[i])
    );
  end

  assign buffer_empty_o = &lane_empty_s;

  idma_byte_lane_buffer_checker #(
    .StrbWidth (StrbWidth),
    .Depth     (Depth)
  ) i_checker (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .buffer_out_valid (buffer_out_valid_o),
    .buffer_empty     (buffer_empty_o)
  );

endmodule

// File: tb/tb_idma_byte_lane_buffer.sv
// Scoreboard bench: a Depth=3 and a Depth=1 buffer (4 lanes each) share one
// stimulus stream; per-lane expectation queues model the intended behaviour.
module tb_idma_byte_lane_buffer;

  logic            clk = 1'b0;
  logic            rst;
  logic            clr;
  logic [3:0][7:0] din;
  logic [3:0]      vin;
  logic [3:0]      rdy_out;

  logic [3:0]      in_ready  [2];
  logic [3:0][7:0] dout      [2];
  logic [3:0]      out_valid [2];
  logic            empty     [2];

  int              checks   = 0;
  int              failures = 0;
  bit              armed    = 1'b0;
  int              cnt_m [2][4];
  logic [7:0]      exp_q [2][4][$];

  always #5 clk = ~clk;

  idma_byte_lane_buffer #(.StrbWidth(4), .Depth(3)) dut_d3 (
    .clk_i(clk), .rst_i(rst), .clear_i(clr),
    .buffer_in_i(din), .buffer_in_valid_i(vin), .buffer_in_ready_o(in_ready[0]),
    .buffer_out_o(dout[0]), .buffer_out_valid_o(out_valid[0]),
    .buffer_out_ready_i(rdy_out), .buffer_empty_o(empty[0])
  );

  idma_byte_lane_buffer #(.StrbWidth(4), .Depth(1)) dut_d1 (
    .clk_i(clk), .rst_i(rst), .clear_i(clr),
    .buffer_in_i(din), .buffer_in_valid_i(vin), .buffer_in_ready_o(in_ready[1]),
    .buffer_out_o(dout[1]), .buffer_out_valid_o(out_valid[1]),
    .buffer_out_ready_i(rdy_out), .buffer_empty_o(empty[1])
  );

  function automatic int depth_of(input int g);
    return (g == 0) ? 3 : 1;
  endfunction

  task automatic chk(input string name, input int g, input int i,
                     input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s depth%0d lane%0d got=%0h want=%0h", name, depth_of(g), i, act, want);
    end
  endtask

  // One clock edge; the reference queues follow what the edge must do.
  task automatic tick();
    bit pu, po;
    @(posedge clk);
    for (int g = 0; g < 2; g++) begin
      for (int i = 0; i < 4; i++) begin
        if (rst || clr) begin
          cnt_m[g][i] = 0;
          exp_q[g][i].delete();
        end else begin
          pu = vin[i] && (cnt_m[g][i] < depth_of(g));
          po = rdy_out[i] && (cnt_m[g][i] > 0);
          if (po) void'(exp_q[g][i].pop_front());
          if (pu) exp_q[g][i].push_back(din[i]);
          cnt_m[g][i] = cnt_m[g][i] + (pu ? 1 : 0) - (po ? 1 : 0);
        end
      end
    end
    armed = 1'b1;
    #1;
  endtask

  initial begin
    int n_acc;
    bit seen;
    fork
      begin : monitor
        logic all_e;
        logic [31:0] want;
        forever begin
          @(negedge clk);
          if (armed) begin
            for (int g = 0; g < 2; g++) begin
              all_e = 1'b1;
              for (int i = 0; i < 4; i++) begin
                chk("out_valid", g, i, 32'(out_valid[g][i]), 32'(cnt_m[g][i] != 0));
                chk("in_ready", g, i, 32'(in_ready[g][i]), 32'(cnt_m[g][i] < depth_of(g)));
                if (cnt_m[g][i] != 0) begin
                  all_e = 1'b0;
                  want = (exp_q[g][i].size() > 0) ? 32'(exp_q[g][i][0]) : 32'hFFFF_FFFF;
                end else begin
                  want = 32'h0;
                end
                chk("out_data", g, i, 32'(dout[g][i]), want);
              end
              chk("empty", g, 0, 32'(empty[g]), 32'(all_e));
            end
          end
        end
      end
    join_none

    // Reset with garbage on every input.
    rst = 1'b1; clr = 1'b0; vin = 4'hF; rdy_out = 4'hF; din = $urandom();
    tick(); tick();
    rst = 1'b0; vin = 4'h0; rdy_out = 4'h0;
    tick();

    // Fill lane 0 past capacity, then drain it.
    for (int k = 0; k < 4; k++) begin
      din[0] = 8'hA1 + 8'(k); vin = 4'b0001;
      tick();
    end
    vin = 4'h0;
    chk("full_ready0", 0, 0, 32'(in_ready[0][0]), 32'h0);
    for (int k = 0; k < 3; k++) begin
      rdy_out = 4'b0001;
      tick();
    end
    rdy_out = 4'h0;
    tick();

    // Continuous push+pop on lane 2 from one resident byte.
    din[2] = 8'h50; vin = 4'b0100;
    tick();
    for (int k = 1; k < 9; k++) begin
      din[2] = 8'h50 + 8'(k); vin = 4'b0100; rdy_out = 4'b0100;
      tick();
    end
    vin = 4'h0;
    tick();
    rdy_out = 4'h0;
    tick();

    // Unaligned arrival, aligned departure as one beat.
    din = {8'h33, 8'h22, 8'h11, 8'h00}; vin = 4'b1110;
    tick();
    din[0] = 8'h44; vin = 4'b0001;
    tick();
    vin = 4'h0;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (!seen && (out_valid[0] == 4'hF)) seen = 1'b1;
      if (!seen) tick();
    end
    chk("beat_seen", 0, 0, 32'(seen), 32'h1);
    chk("beat_d3", 0, 0, dout[0], 32'h3322_1144);
    chk("beat_d1", 1, 0, dout[1], 32'h3322_1144);
    rdy_out = 4'hF;
    tick();
    rdy_out = 4'h0;
    tick();

    // Clear with lanes 0 and 3 occupied and a push on lane 3 in the same cycle.
    for (int k = 0; k < 2; k++) begin
      din[0] = 8'hC0 + 8'(k); din[3] = 8'hD0 + 8'(k); vin = 4'b1001;
      tick();
    end
    clr = 1'b1; din[3] = 8'hEE; vin = 4'b1000;
    tick();
    clr = 1'b0; vin = 4'h0;
    chk("clear_empty", 0, 0, 32'(empty[0]), 32'h1);
    chk("clear_ready", 0, 0, 32'(in_ready[0]), 32'hF);
    tick();

    // Depth=1 lane with push and pop held high accepts on alternate cycles.
    n_acc = 0;
    for (int k = 0; k < 10; k++) begin
      din[0] = 8'h70 + 8'(k); vin = 4'b0001; rdy_out = 4'b0001;
      #1;
      if (vin[0] && in_ready[1][0]) n_acc++;
      tick();
    end
    chk("d1_accepts", 1, 0, 32'(n_acc), 32'd5);
    vin = 4'h0; rdy_out = 4'hF;
    tick(); tick();

    // Randomized traffic with occasional clear and reset.
    for (int k = 0; k < 400; k++) begin
      din     = {8'($urandom()), 8'($urandom()), 8'($urandom()), 8'($urandom())};
      vin     = 4'($urandom_range(0, 15));
      rdy_out = 4'($urandom_range(0, 15));
      clr     = ($urandom_range(0, 39) == 0);
      rst     = ($urandom_range(0, 149) == 0);
      tick();
    end
    rst = 1'b0; clr = 1'b0; vin = 4'h0; rdy_out = 4'hF;
    for (int k = 0; k < 4; k++) tick();
    chk("final_empty_d3", 0, 0, 32'(empty[0]), 32'h1);
    chk("final_empty_d1", 1, 0, 32'(empty[1]), 32'h1);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
